// File: rtl/mem_stage.sv
// Memory-access stage: drives dmemory combinationally, checks faults, extends load data into a 1-entry MEM/WB register.
// Latency 1 cycle; req_ready drops while the MEM/WB entry is full and wb_ready is low, and no store commits then.
module mem_stage #(
  parameter logic [31:0] DMEM_BASE = 32'h01000000,
  parameter int unsigned DMEM_SIZE = 1428,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic [31:0]      dmem_address,
  output logic             dmem_read_write,
  output logic [1:0]       dmem_access_size,
  output logic [31:0]      dmem_data_in,
  input  logic [31:0]      dmem_data_out,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [1:0]       wb_fault,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] fault_cnt
);

  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic [1:0]       r_wb_fault;
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_store_cnt;
  logic [CNT_W-1:0] r_fault_cnt;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_ld_f3_ok;
  logic        w_st_f3_ok;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_out_of_range;
  logic [32:0] w_nbytes;
  logic [32:0] w_limit;
  logic [32:0] w_addr_ext;
  logic [1:0]  w_fault;
  logic [31:0] w_load_data;

  assign req_ready = !reset && (!r_wb_valid || wb_ready);
  assign w_accept  = req_valid && req_ready;

  assign dmem_address     = req_addr;
  assign dmem_data_in     = req_wdata;
  assign dmem_access_size = req_funct3[1:0];

  assign w_is_mem   = req_load || req_store;
  // Legal loads: 000,001,010,100,101. Legal stores: 000,001,010.
  assign w_ld_f3_ok = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
  assign w_st_f3_ok = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
  assign w_illegal  = (req_load && req_store) ||
                      (req_load && !w_ld_f3_ok) ||
                      (req_store && !w_st_f3_ok);
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign w_nbytes   = (req_funct3[1:0] == 2'b00) ? 33'd1 :
                      (req_funct3[1:0] == 2'b01) ? 33'd2 : 33'd4;
  // 33-bit arithmetic so an access near 2^32 cannot wrap back into range.
  assign w_limit        = {1'b0, DMEM_BASE} + 33'(DMEM_SIZE);
  assign w_addr_ext     = {1'b0, req_addr};
  assign w_out_of_range = (w_addr_ext < {1'b0, DMEM_BASE}) ||
                          ((w_addr_ext + w_nbytes) > w_limit);

  assign w_fault = !w_is_mem      ? 2'd0 :
                   w_illegal      ? 2'd3 :
                   w_misalign     ? 2'd1 :
                   w_out_of_range ? 2'd2 : 2'd0;

  assign dmem_read_write = w_accept && req_store && (w_fault == 2'd0);

  always_comb begin
    w_load_data = dmem_data_out;
    case (req_funct3)
      3'b000:  w_load_data = {{24{dmem_data_out[7]}}, dmem_data_out[7:0]};
      3'b001:  w_load_data = {{16{dmem_data_out[15]}}, dmem_data_out[15:0]};
      3'b100:  w_load_data = {24'd0, dmem_data_out[7:0]};
      3'b101:  w_load_data = {16'd0, dmem_data_out[15:0]};
      default: w_load_data = dmem_data_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'd0;
      r_wb_fault  <= 2'd0;
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
      r_fault_cnt <= '0;
    end else if (w_accept) begin
      r_wb_valid <= 1'b1;
      r_wb_fault <= w_fault;
      if (w_fault != 2'd0) begin
        r_wb_rd     <= 5'd0;
        r_wb_data   <= req_addr;
        r_fault_cnt <= r_fault_cnt + CNT_W'(1);
      end else if (req_load) begin
        r_wb_rd    <= req_rd;
        r_wb_data  <= w_load_data;
        r_load_cnt <= r_load_cnt + CNT_W'(1);
      end else if (req_store) begin
        r_wb_rd     <= 5'd0;
        r_wb_data   <= 32'd0;
        r_store_cnt <= r_store_cnt + CNT_W'(1);
      end else begin
        r_wb_rd   <= req_rd;
        r_wb_data <= req_wdata;
      end
    end else if (r_wb_valid && wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign wb_fault  = r_wb_fault;
  assign load_cnt  = r_load_cnt;
  assign store_cnt = r_store_cnt;
  assign fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-array dmemory model, vector table with a scoreboard, plus backpressure and reset sequences.
module tb_mem_stage;
  localparam logic [31:0] BASE = 32'h01000000;
  localparam int          SIZE = 1428;
  localparam int          CW   = 16;
  localparam int          NV   = 25;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_load = 1'b0;
  logic          req_store = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic [4:0]    req_rd = 5'd0;
  logic [31:0]   dmem_address;
  logic          dmem_read_write;
  logic [1:0]    dmem_access_size;
  logic [31:0]   dmem_data_in;
  logic [31:0]   dmem_data_out;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic [1:0]    wb_fault;
  logic [CW-1:0] load_cnt;
  logic [CW-1:0] store_cnt;
  logic [CW-1:0] fault_cnt;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem_address(dmem_address), .dmem_read_write(dmem_read_write),
    .dmem_access_size(dmem_access_size), .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault),
    .load_cnt(load_cnt), .store_cnt(store_cnt), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  // dmemory model: byte array, combinational read, write on the rising edge.
  logic [7:0] mem [SIZE];
  int         wr_cnt;

  always_comb begin
    dmem_data_out = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if ((dmem_address + 32'(k) - BASE) < 32'(SIZE))
        dmem_data_out[8*k +: 8] = mem[dmem_address + 32'(k) - BASE];
    end
  end

  initial begin
    int nb;
    wr_cnt = 0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(i);
    forever begin
      @(posedge clk);
      if (dmem_read_write) begin
        wr_cnt++;
        nb = (dmem_access_size == 2'd0) ? 1 : (dmem_access_size == 2'd1) ? 2 : 4;
        for (int k = 0; k < nb; k++) begin
          if ((dmem_address + 32'(k) - BASE) < 32'(SIZE))
            mem[dmem_address + 32'(k) - BASE] = dmem_data_in[8*k +: 8];
        end
      end
    end
  end

  function automatic logic [31:0] mem_word(input int off);
    return {mem[off+3], mem[off+2], mem[off+1], mem[off]};
  endfunction

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [1:0]  e_fault;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_ld = 0;
  int   exp_st = 0;
  int   exp_ft = 0;
  int   exp_wr = 0;

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                              input logic [4:0] erd, input logic [31:0] edata, input logic [1:0] efault);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.e_rd = erd; v.e_data = edata; v.e_fault = efault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
  endtask

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    drive(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
    @(negedge clk);
    chk($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
    if (req_ready) begin
      e.rd = v.e_rd; e.data = v.e_data; e.fault = v.e_fault;
      sb.push_back(e);
      if (v.e_fault != 2'd0) exp_ft++;
      else if (v.ld) exp_ld++;
      else if (v.st) begin exp_st++; exp_wr++; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d_scoreboard: got empty queue, expected one entry", idx);
    end else begin
      g = sb.pop_front();
      chk($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_wb_rd", idx), 32'(wb_rd), 32'(g.rd));
      chk($sformatf("v%0d_wb_data", idx), wb_data, g.data);
      chk($sformatf("v%0d_wb_fault", idx), 32'(wb_fault), 32'(g.fault));
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_load_cnt"}, 32'(load_cnt), 32'(exp_ld));
    chk({tag, "_store_cnt"}, 32'(store_cnt), 32'(exp_st));
    chk({tag, "_fault_cnt"}, 32'(fault_cnt), 32'(exp_ft));
    chk({tag, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
  endtask

  initial begin
    //              ld    st    f3      addr          wdata         rd     e_rd   e_data        e_fault
    vecs[0]  = mk(1'b0, 1'b1, 3'b010, 32'h01000010, 32'hDEADBEEF, 5'd5,  5'd0,  32'h00000000, 2'd0);
    vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h01000010, 32'h0,        5'd1,  5'd1,  32'hFFFFFFEF, 2'd0);
    vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h01000010, 32'h0,        5'd2,  5'd2,  32'h000000EF, 2'd0);
    vecs[3]  = mk(1'b1, 1'b0, 3'b001, 32'h01000010, 32'h0,        5'd3,  5'd3,  32'hFFFFBEEF, 2'd0);
    vecs[4]  = mk(1'b1, 1'b0, 3'b101, 32'h01000010, 32'h0,        5'd4,  5'd4,  32'h0000BEEF, 2'd0);
    vecs[5]  = mk(1'b1, 1'b0, 3'b010, 32'h01000010, 32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 2'd0);
    vecs[6]  = mk(1'b0, 1'b1, 3'b001, 32'h01000011, 32'h00001234, 5'd3,  5'd0,  32'h01000011, 2'd1);
    vecs[7]  = mk(1'b1, 1'b0, 3'b010, 32'h01000010, 32'h0,        5'd2,  5'd2,  32'hDEADBEEF, 2'd0);
    vecs[8]  = mk(1'b1, 1'b0, 3'b010, 32'h01000590, 32'h0,        5'd7,  5'd7,  32'h93929190, 2'd0);
    vecs[9]  = mk(1'b1, 1'b0, 3'b010, 32'h01000594, 32'h0,        5'd7,  5'd0,  32'h01000594, 2'd2);
    vecs[10] = mk(1'b1, 1'b0, 3'b010, 32'h00FFFFFC, 32'h0,        5'd7,  5'd0,  32'h00FFFFFC, 2'd2);
    vecs[11] = mk(1'b1, 1'b0, 3'b011, 32'h01000010, 32'h0,        5'd8,  5'd0,  32'h01000010, 2'd3);
    vecs[12] = mk(1'b1, 1'b1, 3'b010, 32'h01000020, 32'hFFFFFFFF, 5'd8,  5'd0,  32'h01000020, 2'd3);
    vecs[13] = mk(1'b0, 1'b0, 3'b111, 32'h01000011, 32'h12345678, 5'd9,  5'd9,  32'h12345678, 2'd0);
    vecs[14] = mk(1'b0, 1'b1, 3'b000, 32'h01000013, 32'h000000AB, 5'd10, 5'd0,  32'h00000000, 2'd0);
    vecs[15] = mk(1'b1, 1'b0, 3'b010, 32'h01000010, 32'h0,        5'd11, 5'd11, 32'hABADBEEF, 2'd0);
    vecs[16] = mk(1'b1, 1'b0, 3'b001, 32'h01000592, 32'h0,        5'd12, 5'd12, 32'hFFFF9392, 2'd0);
    vecs[17] = mk(1'b1, 1'b0, 3'b100, 32'h01000593, 32'h0,        5'd13, 5'd13, 32'h00000093, 2'd0);
    vecs[18] = mk(1'b1, 1'b0, 3'b001, 32'h01000593, 32'h0,        5'd13, 5'd0,  32'h01000593, 2'd1);
    vecs[19] = mk(1'b0, 1'b1, 3'b100, 32'h01000030, 32'h0,        5'd0,  5'd0,  32'h01000030, 2'd3);
    vecs[20] = mk(1'b1, 1'b0, 3'b010, 32'h01000592, 32'h0,        5'd6,  5'd0,  32'h01000592, 2'd1);
    vecs[21] = mk(1'b0, 1'b1, 3'b001, 32'h01000592, 32'h00005555, 5'd6,  5'd0,  32'h00000000, 2'd0);
    vecs[22] = mk(1'b1, 1'b0, 3'b101, 32'h01000592, 32'h0,        5'd14, 5'd14, 32'h00005555, 2'd0);
    vecs[23] = mk(1'b1, 1'b0, 3'b000, 32'h00000000, 32'h0,        5'd1,  5'd0,  32'h00000000, 2'd2);
    vecs[24] = mk(1'b1, 1'b0, 3'b100, 32'h01000594, 32'h0,        5'd1,  5'd0,  32'h01000594, 2'd2);

    // Reset with a store presented: nothing may be accepted or written.
    drive(1'b0, 1'b1, 3'b010, 32'h01000010, 32'hCAFEF00D, 5'd1);
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_fault", 32'(wb_fault), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_dmem_rw", 32'(dmem_read_write), 32'd0);
    chk_counters("rst");
    reset = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) step(i, vecs[i]);
    chk_counters("table");

    // Drain with no new request: valid clears, fields hold.
    @(posedge clk); #1;
    chk("drain_wb_valid", 32'(wb_valid), 32'd0);
    chk("drain_wb_data_hold", wb_data, 32'h01000594);
    chk("drain_wb_fault_hold", 32'(wb_fault), 32'd2);

    // Backpressure: fill the register with wb_ready low, then stall a store for 3 cycles.
    wb_ready = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0BADF00D, 5'd4);
    @(negedge clk);
    chk("bp_fill_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_fill_valid", 32'(wb_valid), 32'd1);
    chk("bp_fill_rd", 32'(wb_rd), 32'd4);
    drive(1'b0, 1'b1, 3'b010, 32'h01000040, 32'h11223344, 5'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_dmem_rw", c), 32'(dmem_read_write), 32'd0);
      chk($sformatf("bp%0d_wb_valid", c), 32'(wb_valid), 32'd1);
      chk($sformatf("bp%0d_wb_rd", c), 32'(wb_rd), 32'd4);
      chk($sformatf("bp%0d_wb_data", c), wb_data, 32'h0BADF00D);
      @(posedge clk); #1;
    end
    chk("bp_stalled_mem", mem_word(32'h40), 32'h43424140);
    wb_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    chk("bp_release_rw", 32'(dmem_read_write), 32'd1);
    @(posedge clk); #1;
    exp_st++; exp_wr++;
    req_valid = 1'b0;
    chk("bp_commit_valid", 32'(wb_valid), 32'd1);
    chk("bp_commit_rd", 32'(wb_rd), 32'd0);
    chk("bp_commit_data", wb_data, 32'd0);
    chk("bp_commit_mem", mem_word(32'h40), 32'h11223344);
    chk_counters("bp");

    // Asynchronous reset while a store waits behind a full register.
    wb_ready = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 32'h01000044, 32'h55667788, 5'd9);
    @(negedge clk);
    chk("ar_wait_ready", 32'(req_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    exp_ld = 0; exp_st = 0; exp_ft = 0;
    chk("ar_wb_valid", 32'(wb_valid), 32'd0);
    chk("ar_wb_rd", 32'(wb_rd), 32'd0);
    chk("ar_wb_data", wb_data, 32'd0);
    chk("ar_wb_fault", 32'(wb_fault), 32'd0);
    chk("ar_req_ready", 32'(req_ready), 32'd0);
    chk("ar_dmem_rw", 32'(dmem_read_write), 32'd0);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    chk_counters("ar");
    chk("ar_mem", mem_word(32'h44), 32'h47464544);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    step(100, mk(1'b1, 1'b0, 3'b010, 32'h01000040, 32'h0, 5'd15, 5'd15, 32'h11223344, 2'd0));
    chk_counters("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the processor, placed between the EX/MEM pipeline register and `dmemory`. It accepts one EX result per cycle over a valid/ready handshake and drives the `dmemory` port combinationally. It selects and sign- or zero-extends load data, blocks illegal, misaligned and out-of-range accesses, and registers the result into a single-entry MEM/WB output register with backpressure. It also keeps load, store and fault event counters.

## Interface
Parameters:
- `DMEM_BASE`, default 32'h01000000: first valid data byte address.
- `DMEM_SIZE`, default 1428: number of valid data bytes.
- `CNT_W`, default 16: width of the event counters.

Ports:
- `clk`, in, 1: clock. Everything is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: EX result is present.
- `req_ready`, out, 1: the stage accepts the request this cycle.
- `req_load`, in, 1: the request is a load.
- `req_store`, in, 1: the request is a store.
- `req_funct3`, in, 3: RV32I load/store funct3.
- `req_addr`, in, 32: effective byte address (ALU result).
- `req_wdata`, in, 32: store data, or the ALU result when the request is not a memory op.
- `req_rd`, in, 5: destination register.
- `dmem_address`, out, 32: connects to `dmemory.address`.
- `dmem_read_write`, out, 1: 1 means write.
- `dmem_access_size`, out, 2: 0 byte, 1 half, 2 word.
- `dmem_data_in`, out, 32: store data.
- `dmem_data_out`, in, 32: combinational read data, holding bytes address..address+3 with address in [7:0].
- `wb_valid`, out, 1: the MEM/WB register is full.
- `wb_ready`, in, 1: WB consumes the entry.
- `wb_rd`, out, 5: destination register; 0 means no register write.
- `wb_data`, out, 32: result, or the faulting address when `wb_fault` is nonzero.
- `wb_fault`, out, 2: 0 ok, 1 misaligned, 2 out of range, 3 illegal.
- `load_cnt`, out, CNT_W: number of loads completed.
- `store_cnt`, out, CNT_W: number of stores completed.
- `fault_cnt`, out, CNT_W: number of faulting requests.

## Operation
- `req_ready` = !reset && (!wb_valid || wb_ready). Accept = req_valid && req_ready.
- `dmem_address` = req_addr; `dmem_data_in` = req_wdata; `dmem_access_size` = req_funct3[1:0] (value 3 is never used with a write).
- `dmem_read_write` = accept && req_store && no fault. In every other case it is 0, so `dmemory` reads.
- Fault checks are evaluated only for memory ops, in this priority order:
  - illegal:
    - req_load && req_store; or
    - a load with funct3 not in {000, 001, 010, 100, 101}; or
    - a store with funct3 not in {000, 001, 010}.
  - misaligned: half access with addr[0]=1, or word access with addr[1:0]≠0.
  - out of range: addr < DMEM_BASE, or addr+nbytes > DMEM_BASE+DMEM_SIZE. The comparison is done in 33 bits so there is no wrap.
- Load data by funct3:
  - 000: sign-extend [7:0].
  - 001: sign-extend [15:0].
  - 010: all 32 bits.
  - 100: zero-extend [7:0].
  - 101: zero-extend [15:0].
- MEM/WB register contents on accept:
  - Load ok: wb_rd = req_rd, wb_data = extended load data, wb_fault = 0.
  - Store ok: wb_rd = 0, wb_data = 0, wb_fault = 0. The write commits at this same edge.
  - Not a memory op: wb_rd = req_rd, wb_data = req_wdata, wb_fault = 0.
  - Fault: wb_rd = 0, wb_data = req_addr, wb_fault = code. Memory is not modified.
- Counters wrap modulo 2^CNT_W. On accept, exactly one counter increments for a load ok, a store ok or a fault. Non-memory ops count nothing.

## Timing
- Reset values: wb_valid 0, wb_rd 0, wb_data 0, wb_fault 0, all counters 0. While reset is asserted, req_ready and dmem_read_write are 0.
- Latency is 1 cycle: a request accepted at edge N is visible on `wb_*` after edge N.
- Throughput is one request per cycle while wb_ready stays 1.
- On each edge the register updates as follows:
  - Accept: the register loads and wb_valid=1.
  - Else, wb_valid && wb_ready: wb_valid clears to 0. The other wb_* fields hold their values.
  - Else, wb_valid && !wb_ready: all wb_* hold, req_ready=0, and no write reaches memory.
- Simultaneous drain and accept (wb_ready=1 while full) replaces the entry in the same cycle with no bubble.
- Reset asserted mid-stall discards the held entry. A store presented during reset is never written.
- Requesters must hold the req_* signals stable while req_valid=1 and req_ready=0.

## Test plan
- Store then load:
  - Stimulus: sw 32'hDEADBEEF to 32'h01000010, then lb / lbu / lh / lhu / lw at 32'h01000010.
  - Required: FFFFFFEF, 000000EF, FFFFBEEF, 0000BEEF, DEADBEEF, one per cycle with wb_valid back-to-back.
- Misaligned store:
  - Stimulus: sh at 32'h01000011.
  - Required: wb_fault=1, wb_data=32'h01000011, wb_rd=0, dmem_read_write never 1, fault_cnt=1. A following lw at 32'h01000010 still returns the old word.
- Range:
  - Stimulus: lw at 32'h01000590, then lw at 32'h01000594, then lw at 32'h00FFFFFC.
  - Required: the first is ok; the second and third return wb_fault=2.
- Illegal:
  - Stimulus: a load with funct3=011, then a request with req_load=req_store=1.
  - Required: wb_fault=3 both times, and no write occurs.
- Backpressure:
  - Stimulus: hold wb_ready=0 for 3 cycles while a store waits.
  - Required: req_ready=0 and dmem_read_write=0 throughout, and the wb_* outputs are stable. The store commits on the edge after wb_ready returns to 1.
- Reset:
  - Stimulus: assert reset asynchronously while a store is waiting.
  - Required: all outputs go to 0 immediately, the memory location is unchanged, and all counters are 0.
